// File: rtl/lsb_rs_multi_pkg.sv
// Shared defaults, constants and helpers for the load/store reservation station.
package lsb_rs_multi_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefTagW  = 4;
  localparam int unsigned DefOpW   = 6;

  // Operand-present and slot-occupancy encodings.
  localparam logic Valid   = 1'b1;
  localparam logic Invalid = 1'b0;
  localparam logic Null    = 1'b0;

  // Bit offset of channel ch inside a packed CDB bus of w-bit fields.
  function automatic int unsigned cdb_lsb(int unsigned ch, int unsigned w);
    return ch * w;
  endfunction

endpackage

// File: rtl/lsb_rs_age_matrix.sv
// Age matrix: tracks allocation order of entries and picks the oldest ready one.
module lsb_rs_age_matrix #(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] ready_i,
  output logic [DEPTH-1:0] oldest_o
);

  // older_q[i][j] set: entry i was allocated before entry j.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  // New entries become younger than everything; freed entries drop all relations.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      older_d[i] = older_q[i];
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (alloc_i[j]) older_d[i][j] = 1'b1;
        if (alloc_i[i] || free_i[i] || free_i[j]) older_d[i][j] = 1'b0;
      end
    end
  end

  // Matrix state, synchronously cleared on reset/flush.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (clear_i) begin
        older_q[i] <= '0;
      end else if (en_i) begin
        older_q[i] <= older_d[i];
      end
    end
  end

  // An entry wins when no other ready entry is older than it.
  always_comb begin
    oldest_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (ready_i[j] && older_q[j][i]) blocked = 1'b1;
      end
      oldest_o[i] = ready_i[i] && !blocked;
    end
  end

endmodule

// File: rtl/lsb_rs_multi.sv
// Load/store reservation station: DEPTH entries, NCDB-channel operand wakeup,
// oldest-ready selection and a single valid/ready issue register.
// Optional: LSB_RS_WAKEUP_BYPASS_EN lets a same-cycle CDB hit make an entry ready.
module lsb_rs_multi
  import lsb_rs_multi_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NCDB   = 4,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned TAG_W  = DefTagW,
  parameter int unsigned OP_W   = DefOpW
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rdy_i,
  input  logic                       clear_i,
  input  logic                       disp_valid_i,
  input  logic [OP_W-1:0]            disp_op_i,
  input  logic [DATA_W-1:0]          disp_imm_i,
  input  logic [DATA_W-1:0]          disp_pc_i,
  input  logic                       disp_r1_valid_i,
  input  logic [DATA_W-1:0]          disp_r1_data_i,
  input  logic [TAG_W-1:0]           disp_r1_tag_i,
  input  logic                       disp_r2_valid_i,
  input  logic [DATA_W-1:0]          disp_r2_data_i,
  input  logic [TAG_W-1:0]           disp_r2_tag_i,
  input  logic [TAG_W-1:0]           disp_dest_tag_i,
  input  logic [NCDB-1:0]            cdb_valid_i,
  input  logic [NCDB*TAG_W-1:0]      cdb_tag_i,
  input  logic [NCDB*DATA_W-1:0]     cdb_data_i,
  output logic                       rs_full_o,
  output logic [$clog2(DEPTH+1)-1:0] rs_count_o,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [OP_W-1:0]            issue_op_o,
  output logic [DATA_W-1:0]          issue_r1_o,
  output logic [DATA_W-1:0]          issue_r2_o,
  output logic [DATA_W-1:0]          issue_imm_o,
  output logic [DATA_W-1:0]          issue_pc_o,
  output logic [TAG_W-1:0]           issue_dest_tag_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  occ_q, r1v_q, r2v_q;
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [DATA_W-1:0] imm_q  [DEPTH];
  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] r1_q   [DEPTH];
  logic [DATA_W-1:0] r2_q   [DEPTH];
  logic [TAG_W-1:0]  r1t_q  [DEPTH];
  logic [TAG_W-1:0]  r2t_q  [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [CntW-1:0]   count_q;

  logic              iss_v_q;
  logic [OP_W-1:0]   iss_op_q;
  logic [DATA_W-1:0] iss_r1_q, iss_r2_q, iss_imm_q, iss_pc_q;
  logic [TAG_W-1:0]  iss_dest_q;

  logic [TAG_W-1:0]  ch_tag  [NCDB];
  logic [DATA_W-1:0] ch_data [NCDB];
  logic [DEPTH-1:0]  r1_hit, r2_hit;
  logic [DATA_W-1:0] r1_cdb [DEPTH];
  logic [DATA_W-1:0] r2_cdb [DEPTH];
  logic              d1_hit, d2_hit;
  logic [DATA_W-1:0] d1_cdb, d2_cdb;

  logic              full, accept, alloc_found, issue_load, free_any;
  logic [DEPTH-1:0]  alloc_oh, ready, oldest, free_oh;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_r1, sel_r2, sel_imm, sel_pc;
  logic [TAG_W-1:0]  sel_dest;

  for (genvar k = 0; k < NCDB; k++) begin : g_cdb
    assign ch_tag[k]  = cdb_tag_i[cdb_lsb(k, TAG_W) +: TAG_W];
    assign ch_data[k] = cdb_data_i[cdb_lsb(k, DATA_W) +: DATA_W];
  end

  assign full       = (count_q == CntW'(DEPTH));
  assign accept     = disp_valid_i && !full;
  assign issue_load = !iss_v_q || issue_ready_i;
  assign free_oh    = issue_load ? oldest : '0;
  assign free_any   = |free_oh;

  // Lowest free index receives the dispatched op.
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!occ_q[i] && !alloc_found) begin
        alloc_oh[i] = accept;
        alloc_found = 1'b1;
      end
    end
  end

  // CDB tag match for waiting operands and for the dispatching op; lowest channel wins.
  always_comb begin
    r1_hit = '0;
    r2_hit = '0;
    d1_hit = 1'b0;
    d2_hit = 1'b0;
    d1_cdb = '0;
    d2_cdb = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      r1_cdb[i] = '0;
      r2_cdb[i] = '0;
    end
    for (int unsigned k = 0; k < NCDB; k++) begin
      if (cdb_valid_i[k]) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (occ_q[i] && !r1v_q[i] && !r1_hit[i] && r1t_q[i] == ch_tag[k]) begin
            r1_hit[i] = 1'b1;
            r1_cdb[i] = ch_data[k];
          end
          if (occ_q[i] && !r2v_q[i] && !r2_hit[i] && r2t_q[i] == ch_tag[k]) begin
            r2_hit[i] = 1'b1;
            r2_cdb[i] = ch_data[k];
          end
        end
        if (!disp_r1_valid_i && !d1_hit && disp_r1_tag_i == ch_tag[k]) begin
          d1_hit = 1'b1;
          d1_cdb = ch_data[k];
        end
        if (!disp_r2_valid_i && !d2_hit && disp_r2_tag_i == ch_tag[k]) begin
          d2_hit = 1'b1;
          d2_cdb = ch_data[k];
        end
      end
    end
  end

`ifdef LSB_RS_WAKEUP_BYPASS_EN
  assign ready = occ_q & (r1v_q | r1_hit) & (r2v_q | r2_hit);
`else
  assign ready = occ_q & r1v_q & r2v_q;
`endif

  lsb_rs_age_matrix #(
    .DEPTH(DEPTH)
  ) u_age (
    .clk_i   (clk_i),
    .clear_i (rst_i || clear_i),
    .en_i    (rdy_i),
    .alloc_i (alloc_oh),
    .free_i  (free_oh),
    .ready_i (ready),
    .oldest_o(oldest)
  );

  // Mux the selected entry; a still-missing operand can only be a same-cycle CDB bypass.
  always_comb begin
    sel_op   = '0;
    sel_r1   = '0;
    sel_r2   = '0;
    sel_imm  = '0;
    sel_pc   = '0;
    sel_dest = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (oldest[i]) begin
        sel_op   = op_q[i];
        sel_r1   = r1v_q[i] ? r1_q[i] : r1_cdb[i];
        sel_r2   = r2v_q[i] ? r2_q[i] : r2_cdb[i];
        sel_imm  = imm_q[i];
        sel_pc   = pc_q[i];
        sel_dest = dest_q[i];
      end
    end
  end

  // Control state: occupancy, operand-valid bits, count and the issue register.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      occ_q      <= {DEPTH{Null}};
      r1v_q      <= {DEPTH{Invalid}};
      r2v_q      <= {DEPTH{Invalid}};
      count_q    <= '0;
      iss_v_q    <= 1'b0;
      iss_op_q   <= '0;
      iss_r1_q   <= '0;
      iss_r2_q   <= '0;
      iss_imm_q  <= '0;
      iss_pc_q   <= '0;
      iss_dest_q <= '0;
    end else if (rdy_i) begin
      count_q <= count_q + CntW'(accept) - CntW'(free_any);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          occ_q[i] <= Valid;
          r1v_q[i] <= disp_r1_valid_i || d1_hit;
          r2v_q[i] <= disp_r2_valid_i || d2_hit;
        end else begin
          if (free_oh[i]) occ_q[i] <= Null;
          if (r1_hit[i]) r1v_q[i] <= Valid;
          if (r2_hit[i]) r2v_q[i] <= Valid;
        end
      end
      if (issue_load) begin
        iss_v_q <= free_any;
        if (free_any) begin
          iss_op_q   <= sel_op;
          iss_r1_q   <= sel_r1;
          iss_r2_q   <= sel_r2;
          iss_imm_q  <= sel_imm;
          iss_pc_q   <= sel_pc;
          iss_dest_q <= sel_dest;
        end
      end
    end
  end

  // Entry payload; only meaningful while the matching occupancy bit is set.
  always_ff @(posedge clk_i) begin
    if (rdy_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          op_q[i]   <= disp_op_i;
          imm_q[i]  <= disp_imm_i;
          pc_q[i]   <= disp_pc_i;
          r1t_q[i]  <= disp_r1_tag_i;
          r2t_q[i]  <= disp_r2_tag_i;
          dest_q[i] <= disp_dest_tag_i;
          r1_q[i]   <= disp_r1_valid_i ? disp_r1_data_i : d1_cdb;
          r2_q[i]   <= disp_r2_valid_i ? disp_r2_data_i : d2_cdb;
        end else begin
          if (r1_hit[i]) r1_q[i] <= r1_cdb[i];
          if (r2_hit[i]) r2_q[i] <= r2_cdb[i];
        end
      end
    end
  end

  assign rs_full_o        = full;
  assign rs_count_o       = count_q;
  assign issue_valid_o    = iss_v_q;
  assign issue_op_o       = iss_op_q;
  assign issue_r1_o       = iss_r1_q;
  assign issue_r2_o       = iss_r2_q;
  assign issue_imm_o      = iss_imm_q;
  assign issue_pc_o       = iss_pc_q;
  assign issue_dest_tag_o = iss_dest_q;

endmodule
